uart_tx_sched: RTL and testbench

Transmit scheduler for the monitor UART send engine. Three requesters share the single hex-dump transmit path: memory read-back (24-bit), CPU status (56-bit), and bare CR/LF. The block arbitrates them round-robin and launches one job at a time with a single-cycle start pulse. It holds the payload stable for the whole transmission, waits for the engine's last-character indication, then enforces an inter-job gap. It sits between the monitor command logic and the UART interface block.

---
 rtl/uart_tx_sched.sv | 139 +++++++++++++
 tb/tb_uart_tx_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler for the monitor UART hex-dump engine.
// Launches one job at a time, holds its payload, then waits out the inter-job gap.
//   state  | meaning
//   IDLE   | arbitrate pending requests
//   LAUNCH | ack + start pulse on the outputs, payload latched
//   WAIT   | engine sending; wait for final character or timeout
//   GAP    | inter-job idle gap
module uart_tx_sched #(
  parameter int GAP  = 2,
  parameter int TO_W = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic [23:0] mem_data,
  output logic        mem_ack,
  input  logic        cpu_req,
  input  logic [55:0] cpu_data,
  output logic        cpu_ack,
  input  logic        crlf_req,
  output logic        crlf_ack,
  output logic        rdata_snd_start,
  output logic [23:0] rdata_snd,
  output logic        cpust_start,
  output logic [55:0] cpust_snd,
  output logic        crlf_in,
  input  logic        flushing_wq,
  output logic        sched_busy,
  output logic        job_done,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  state_t          state, state_nxt;
  logic [2:0]      req_vec;
  logic [1:0]      last_grant, grant;
  logic            grant_vld;
  logic [TO_W-1:0] to_cnt;
  logic [3:0]      gap_cnt;
  logic            timeout_hit;
  logic            mem_go, cpu_go, crlf_go, done_d, to_d;

  assign req_vec     = {crlf_req, cpu_req, mem_req};
  assign timeout_hit = (state == S_WAIT) && (to_cnt == '1);

  // Walk offsets from farthest to nearest so the nearest active requester wins.
  always_comb begin : arb
    logic [1:0] idx;
    grant     = 2'd0;
    grant_vld = 1'b0;
    idx       = 2'd0;
    for (int i = 3; i >= 1; i--) begin
      idx = 2'((int'(last_grant) + i) % 3);
      if (req_vec[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (grant_vld) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (flushing_wq || timeout_hit) state_nxt = S_GAP;
      S_GAP:    if (gap_cnt == 4'd0) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Flush beats timeout when both land in the same cycle.
  always_comb begin
    mem_go  = 1'b0;
    cpu_go  = 1'b0;
    crlf_go = 1'b0;
    if (state == S_IDLE && grant_vld) begin
      case (grant)
        2'd0:    mem_go  = 1'b1;
        2'd1:    cpu_go  = 1'b1;
        default: crlf_go = 1'b1;
      endcase
    end
    done_d = (state == S_WAIT) && flushing_wq;
    to_d   = timeout_hit && !flushing_wq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 2'd2;
      to_cnt     <= '0;
      gap_cnt    <= 4'd0;
      rdata_snd  <= '0;
      cpust_snd  <= '0;
    end else begin
      if (state == S_IDLE && grant_vld) begin
        last_grant <= grant;
        to_cnt     <= '0;
      end else if (state == S_WAIT) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (mem_go) rdata_snd <= mem_data;
      if (cpu_go) cpust_snd <= cpu_data;
      if (state == S_WAIT)     gap_cnt <= 4'(GAP - 1);
      else if (state == S_GAP) gap_cnt <= gap_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack         <= 1'b0;
      cpu_ack         <= 1'b0;
      crlf_ack        <= 1'b0;
      rdata_snd_start <= 1'b0;
      cpust_start     <= 1'b0;
      crlf_in         <= 1'b0;
      job_done        <= 1'b0;
      timeout_err     <= 1'b0;
      sched_busy      <= 1'b0;
    end else begin
      mem_ack         <= mem_go;
      cpu_ack         <= cpu_go;
      crlf_ack        <= crlf_go;
      rdata_snd_start <= mem_go;
      cpust_start     <= cpu_go;
      crlf_in         <= crlf_go;
      job_done        <= done_d;
      timeout_err     <= to_d;
      sched_busy      <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a timeline model predicts grants, completions and idle cycles.
module tb_uart_tx_sched;
  localparam int GAP    = 2;
  localparam int TO_W   = 4;
  localparam int TO_MAX = 15;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        mem_req = 1'b0, cpu_req = 1'b0, crlf_req = 1'b0, flushing_wq = 1'b0;
  logic [23:0] mem_data = '0;
  logic [55:0] cpu_data = '0;
  logic        mem_ack, cpu_ack, crlf_ack, rdata_snd_start, cpust_start, crlf_in;
  logic        sched_busy, job_done, timeout_err;
  logic [23:0] rdata_snd;
  logic [55:0] cpust_snd;

  uart_tx_sched #(.GAP(GAP), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_data(mem_data), .mem_ack(mem_ack),
    .cpu_req(cpu_req), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
    .crlf_req(crlf_req), .crlf_ack(crlf_ack),
    .rdata_snd_start(rdata_snd_start), .rdata_snd(rdata_snd),
    .cpust_start(cpust_start), .cpust_snd(cpust_snd), .crlf_in(crlf_in),
    .flushing_wq(flushing_wq), .sched_busy(sched_busy),
    .job_done(job_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [55:0] data; int cyc; } launch_t;
  typedef struct { bit timeout; int cyc; } compl_t;
  launch_t launch_q[$];
  compl_t  compl_q[$];
  int      idle_q[$];

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Reference model: pending set, last winner, payload captured at request time.
  bit [2:0]    pend = 3'b000;
  int          last_g = 2;
  logic [23:0] mem_val = '0;
  logic [55:0] cpu_val = '0;

  function automatic int pick();
    for (int o = 1; o <= 3; o++) begin
      if (pend[(last_g + o) % 3]) return (last_g + o) % 3;
    end
    return -1;
  endfunction

  task automatic drive_req();
    mem_req  = pend[0];
    cpu_req  = pend[1];
    crlf_req = pend[2];
  endtask

  task automatic raise_with(input int id, input logic [55:0] v);
    pend[id] = 1'b1;
    if (id == 0) begin mem_val = v[23:0]; mem_data = mem_val; end
    if (id == 1) begin cpu_val = v; cpu_data = cpu_val; end
    drive_req();
  endtask

  task automatic raise(input int id);
    raise_with(id, 56'({$urandom, $urandom}));
  endtask

  // Idle requesters' data buses churn every cycle; the DUT must not follow them.
  task automatic tick();
    @(negedge clk);
    if (!pend[0]) mem_data = 24'($urandom);
    if (!pend[1]) cpu_data = 56'({$urandom, $urandom});
  endtask

  // Called at the negedge of an IDLE cycle with requests visible; returns in the next IDLE cycle.
  task automatic run_job(input int d, input bit rnd_raise, input int force_id);
    int w;
    launch_t li;
    compl_t ci;
    w = pick();
    li.id = w;
    li.data = (w == 0) ? 56'(mem_val) : cpu_val;
    li.cyc = cyc + 1;
    launch_q.push_back(li);
    last_g = w;
    tick();
    pend[w] = 1'b0;
    if (rnd_raise)
      for (int i = 0; i < 3; i++) if (!pend[i] && $urandom_range(0, 1) == 1) raise(i);
    if (force_id >= 0) raise(force_id);
    drive_req();
    flushing_wq = 1'($urandom_range(0, 1));
    for (int k = 0; k <= TO_MAX; k++) begin
      tick();
      flushing_wq = (k == d);
      if (k == d || k == TO_MAX) begin
        ci.timeout = (d > TO_MAX);
        ci.cyc = cyc + 1;
        compl_q.push_back(ci);
        idle_q.push_back(cyc + GAP + 1);
        break;
      end
    end
    for (int g = 0; g < GAP; g++) begin
      tick();
      flushing_wq = 1'($urandom_range(0, 1));
    end
    tick();
    flushing_wq = 1'($urandom_range(0, 1));
  endtask

  // Monitor: pops expectations whenever the DUT presents a launch or a completion.
  logic [23:0] exp_rdata = '0;
  logic [55:0] exp_cpust = '0;
  logic [2:0]  m_st, m_ak, m_oh;
  logic [1:0]  m_dk, m_ek;
  launch_t     m_li;
  compl_t      m_ci;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rdata = '0;
      exp_cpust = '0;
    end else begin
      m_st = {crlf_in, cpust_start, rdata_snd_start};
      m_ak = {crlf_ack, cpu_ack, mem_ack};
      if (m_st != 3'b000 || m_ak != 3'b000) begin
        if (launch_q.size() == 0) begin
          chk("unexpected_launch", 64'(m_st), 64'd0);
        end else begin
          m_li = launch_q.pop_front();
          m_oh = 3'b001 << m_li.id;
          chk("launch_cycle", 64'(cyc), 64'(m_li.cyc));
          chk("launch_start", 64'(m_st), 64'(m_oh));
          chk("launch_ack", 64'(m_ak), 64'(m_oh));
          chk("busy_in_launch", 64'(sched_busy), 64'd1);
          if (m_li.id == 0) exp_rdata = m_li.data[23:0];
          if (m_li.id == 1) exp_cpust = m_li.data;
        end
      end else if (launch_q.size() != 0 && launch_q[0].cyc <= cyc) begin
        m_li = launch_q.pop_front();
        m_oh = 3'b001 << m_li.id;
        chk("launch_missing", 64'(m_st), 64'(m_oh));
      end
      m_dk = {job_done, timeout_err};
      if (m_dk != 2'b00) begin
        if (compl_q.size() == 0) begin
          chk("unexpected_completion", 64'(m_dk), 64'd0);
        end else begin
          m_ci = compl_q.pop_front();
          m_ek = m_ci.timeout ? 2'b01 : 2'b10;
          chk("completion_cycle", 64'(cyc), 64'(m_ci.cyc));
          chk("completion_kind", 64'(m_dk), 64'(m_ek));
          chk("busy_in_gap", 64'(sched_busy), 64'd1);
        end
      end else if (compl_q.size() != 0 && compl_q[0].cyc <= cyc) begin
        m_ci = compl_q.pop_front();
        m_ek = m_ci.timeout ? 2'b01 : 2'b10;
        chk("completion_missing", 64'(m_dk), 64'(m_ek));
      end
      while (idle_q.size() != 0 && idle_q[0] < cyc) void'(idle_q.pop_front());
      if (idle_q.size() != 0 && idle_q[0] == cyc) begin
        void'(idle_q.pop_front());
        chk("idle_busy", 64'(sched_busy), 64'd0);
      end
      chk("rdata_snd_hold", 64'(rdata_snd), 64'(exp_rdata));
      chk("cpust_snd_hold", 64'(cpust_snd), 64'(exp_cpust));
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_acks"}, 64'({mem_ack, cpu_ack, crlf_ack}), 64'd0);
    chk({tag, "_starts"}, 64'({rdata_snd_start, cpust_start, crlf_in}), 64'd0);
    chk({tag, "_status"}, 64'({sched_busy, job_done, timeout_err}), 64'd0);
    chk({tag, "_rdata_snd"}, 64'(rdata_snd), 64'd0);
    chk({tag, "_cpust_snd"}, 64'(cpust_snd), 64'd0);
  endtask

  initial begin
    logic [63:0] cpu_seed;
    int w, m;
    cpu_seed = 64'h0102030405060708;
    raise_with(0, 56'h12ab34);
    raise_with(1, cpu_seed[55:0]);
    raise(2);
    repeat (2) tick();
    #1 check_reset_outputs("por");
    tick();
    rst_n = 1'b1;
    // Requests held from reset: mem, cpu, crlf, then mem again after its re-request.
    run_job(10, 1'b0, 0);
    run_job(15, 1'b0, -1);
    run_job(20, 1'b0, -1);
    run_job(3, 1'b0, -1);
    for (int j = 0; j < 60; j++) begin
      if (pend == 3'b000) begin
        m = $urandom_range(0, 3);
        for (int q = 1; q <= m; q++) idle_q.push_back(cyc + q);
        repeat (m) begin
          tick();
          flushing_wq = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 3; i++) if ($urandom_range(0, 1) == 1) raise(i);
        if (pend == 3'b000) raise($urandom_range(0, 2));
      end
      run_job($urandom_range(0, 20), 1'b1, -1);
    end
    // Reset in WAIT with crlf pending across it.
    if (pend == 3'b000) raise(0);
    w = pick();
    m_li.id = w;
    m_li.data = (w == 0) ? 56'(mem_val) : cpu_val;
    m_li.cyc = cyc + 1;
    launch_q.push_back(m_li);
    last_g = w;
    tick();
    pend = 3'b000;
    raise(2);
    flushing_wq = 1'b0;
    repeat (3) tick();
    launch_q.delete();
    compl_q.delete();
    idle_q.delete();
    rst_n = 1'b0;
    #1 check_reset_outputs("rst_wait");
    last_g = 2;
    tick();
    #1 check_reset_outputs("rst_hold");
    tick();
    rst_n = 1'b1;
    run_job(4, 1'b0, -1);
    repeat (5) tick();
    chk("launch_q_left", 64'(launch_q.size()), 64'd0);
    chk("compl_q_left", 64'(compl_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
